// File: rtl/ex_pkg.sv
// Shared encodings for the execute stage: ALUOp classes, funct codes,
// ALU control selections and the multiply sequencing states.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADDI  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'b100000;
    localparam logic [5:0] FUNCT_SUB   = 6'b100010;
    localparam logic [5:0] FUNCT_AND   = 6'b100100;
    localparam logic [5:0] FUNCT_OR    = 6'b100101;
    localparam logic [5:0] FUNCT_SLT   = 6'b101010;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MULTU
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_e;

    // Unknown funct codes under the funct class fall back to add.
    function automatic alu_ctrl_e decodeAluCtrl(input logic [1:0] aluOp, input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_SUB:   ctrl = ALU_SUB;
                    FUNCT_AND:   ctrl = ALU_AND;
                    FUNCT_OR:    ctrl = ALU_OR;
                    FUNCT_SLT:   ctrl = ALU_SLT;
                    FUNCT_MULTU: ctrl = ALU_MULTU;
                    default:     ctrl = ALU_ADD;
                endcase
            end
            default: ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/mult_iter.sv
// Iterative shift-add unsigned multiplier: one multiplier bit per step,
// keeping only the low WIDTH bits of the product.
module mult_iter
    import ex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_step,
    input  logic             i_abort,
    input  logic [WIDTH-1:0] i_multiplicand,
    input  logic [WIDTH-1:0] i_multiplier,
    output logic [WIDTH-1:0] o_product,
    output logic             o_last
);

    localparam int CW = $clog2(MUL_CYCLES);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_addend;

    assign w_addend  = r_mcand << r_count;
    assign o_product = r_acc;
    assign o_last    = (r_count == CW'(MUL_CYCLES - 1));

    // Abort wins over start so a flush in the launch cycle never leaves stale operands.
    always_ff @(posedge clk) begin
        if (rst || i_abort) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_start) begin
            r_count  <= '0;
            r_acc    <= '0;
            r_mcand  <= i_multiplicand;
            r_mplier <= i_multiplier;
        end else if (i_step) begin
            if (r_mplier[r_count]) begin
                r_acc <= r_acc + w_addend;
            end
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage with EX/MEM pipeline register and a stalling MULTU sequencer.
// Optional macro EX_OVERFLOW_TRAP_EN suppresses write-back on signed add/sub overflow.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             RegDstIN,
    input  logic             BranchIN,
    input  logic             MemReadIN,
    input  logic             MemtoRegIN,
    input  logic             MemWriteIN,
    input  logic             ALUSrcIN,
    input  logic             RegWriteIN,
    input  logic [1:0]       ALUOpIN,
    input  logic [WIDTH-1:0] nextPcIN,
    input  logic [WIDTH-1:0] readData1IN,
    input  logic [WIDTH-1:0] readData2IN,
    input  logic [WIDTH-1:0] signExtIN,
    input  logic [4:0]       ins20_16IN,
    input  logic [4:0]       ins15_11IN,
    output logic             stall,
    output logic             BranchOUT,
    output logic             MemReadOUT,
    output logic             MemtoRegOUT,
    output logic             MemWriteOUT,
    output logic             RegWriteOUT,
    output logic [WIDTH-1:0] branchTargetOUT,
    output logic [WIDTH-1:0] aluResultOUT,
    output logic [WIDTH-1:0] writeDataOUT,
    output logic             zeroOUT,
    output logic [4:0]       writeRegOUT,
    output logic             ovfOUT
);

    mul_state_e       r_state;
    logic [4:0]       r_mulWriteReg;
    logic             r_mulRegWrite;
    logic [WIDTH-1:0] r_mulWriteData;

    alu_ctrl_e        w_aluCtrl;
    logic [WIDTH-1:0] w_opA, w_opB, w_aluResult, w_branchTarget, w_product;
    logic [4:0]       w_writeReg;
    logic             w_isMul, w_mulLast, w_ovfTrap;

    logic             w_nxBranch, w_nxMemRead, w_nxMemtoReg, w_nxMemWrite, w_nxRegWrite;
    logic [WIDTH-1:0] w_nxBranchTarget, w_nxAluResult, w_nxWriteData;
    logic             w_nxZero, w_nxOvf;
    logic [4:0]       w_nxWriteReg;

    assign w_aluCtrl      = decodeAluCtrl(ALUOpIN, signExtIN[5:0]);
    assign w_isMul        = (w_aluCtrl == ALU_MULTU);
    assign w_opA          = readData1IN;
    assign w_opB          = ALUSrcIN ? signExtIN : readData2IN;
    assign w_branchTarget = nextPcIN + (signExtIN << 2);
    assign w_writeReg     = RegDstIN ? ins15_11IN : ins20_16IN;

    always_comb begin
        w_aluResult = w_opA + w_opB;
        case (w_aluCtrl)
            ALU_SUB: w_aluResult = w_opA - w_opB;
            ALU_AND: w_aluResult = w_opA & w_opB;
            ALU_OR:  w_aluResult = w_opA | w_opB;
            ALU_SLT: w_aluResult = {{(WIDTH-1){1'b0}}, ($signed(w_opA) < $signed(w_opB))};
            default: w_aluResult = w_opA + w_opB;
        endcase
    end

`ifdef EX_OVERFLOW_TRAP_EN
    // Overflow when operands agree in sign (add) or differ (sub) and the result sign flips.
    logic w_addOvf, w_subOvf;
    assign w_addOvf  = (w_opA[WIDTH-1] == w_opB[WIDTH-1]) && (w_aluResult[WIDTH-1] != w_opA[WIDTH-1]);
    assign w_subOvf  = (w_opA[WIDTH-1] != w_opB[WIDTH-1]) && (w_aluResult[WIDTH-1] != w_opA[WIDTH-1]);
    assign w_ovfTrap = (ALUOpIN == ALUOP_FUNCT) &&
                       (((signExtIN[5:0] == FUNCT_ADD) && w_addOvf) ||
                        ((signExtIN[5:0] == FUNCT_SUB) && w_subOvf));
`else
    assign w_ovfTrap = 1'b0;
`endif

    // The front end is held while a multiply launches or iterates; flush and reset release it at once.
    assign stall = !rst && !flush && (((r_state == IDLE) && w_isMul) || (r_state == MUL));

    mult_iter #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mult (
        .clk            (clk),
        .rst            (rst),
        .i_start        ((r_state == IDLE) && w_isMul),
        .i_step         (r_state == MUL),
        .i_abort        (flush),
        .i_multiplicand (w_opA),
        .i_multiplier   (w_opB),
        .o_product      (w_product),
        .o_last         (w_mulLast)
    );

    // Next EX/MEM contents: a bubble unless a normal instruction or finished product is ready.
    always_comb begin
        w_nxBranch       = 1'b0;
        w_nxMemRead      = 1'b0;
        w_nxMemtoReg     = 1'b0;
        w_nxMemWrite     = 1'b0;
        w_nxRegWrite     = 1'b0;
        w_nxBranchTarget = '0;
        w_nxAluResult    = '0;
        w_nxWriteData    = '0;
        w_nxZero         = 1'b0;
        w_nxWriteReg     = '0;
        w_nxOvf          = 1'b0;
        if (!flush) begin
            case (r_state)
                IDLE: begin
                    if (!w_isMul) begin
                        w_nxBranch       = BranchIN;
                        w_nxMemRead      = MemReadIN;
                        w_nxMemtoReg     = MemtoRegIN;
                        w_nxMemWrite     = MemWriteIN;
                        w_nxRegWrite     = RegWriteIN && !w_ovfTrap;
                        w_nxBranchTarget = w_branchTarget;
                        w_nxAluResult    = w_aluResult;
                        w_nxWriteData    = readData2IN;
                        w_nxZero         = (w_aluResult == '0);
                        w_nxWriteReg     = w_writeReg;
                        w_nxOvf          = w_ovfTrap;
                    end
                end
                DONE: begin
                    w_nxRegWrite  = r_mulRegWrite;
                    w_nxAluResult = w_product;
                    w_nxWriteData = r_mulWriteData;
                    w_nxZero      = (w_product == '0);
                    w_nxWriteReg  = r_mulWriteReg;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_mulWriteReg   <= '0;
            r_mulRegWrite   <= 1'b0;
            r_mulWriteData  <= '0;
            BranchOUT       <= 1'b0;
            MemReadOUT      <= 1'b0;
            MemtoRegOUT     <= 1'b0;
            MemWriteOUT     <= 1'b0;
            RegWriteOUT     <= 1'b0;
            branchTargetOUT <= '0;
            aluResultOUT    <= '0;
            writeDataOUT    <= '0;
            zeroOUT         <= 1'b0;
            writeRegOUT     <= '0;
            ovfOUT          <= 1'b0;
        end else begin
            BranchOUT       <= w_nxBranch;
            MemReadOUT      <= w_nxMemRead;
            MemtoRegOUT     <= w_nxMemtoReg;
            MemWriteOUT     <= w_nxMemWrite;
            RegWriteOUT     <= w_nxRegWrite;
            branchTargetOUT <= w_nxBranchTarget;
            aluResultOUT    <= w_nxAluResult;
            writeDataOUT    <= w_nxWriteData;
            zeroOUT         <= w_nxZero;
            writeRegOUT     <= w_nxWriteReg;
            ovfOUT          <= w_nxOvf;
            if (flush) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_isMul) begin
                            r_state        <= MUL;
                            r_mulWriteReg  <= w_writeReg;
                            r_mulRegWrite  <= RegWriteIN;
                            r_mulWriteData <= readData2IN;
                        end
                    end
                    MUL:     if (w_mulLast) r_state <= DONE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: expected EX/MEM bundles are queued at drive time
// and compared once the stage registers them. Overflow expectations follow EX_OVERFLOW_TRAP_EN.
module tb_ex_mem_stage;

    typedef struct packed {
        logic        branch;
        logic        memRead;
        logic        memtoReg;
        logic        memWrite;
        logic        regWrite;
        logic [31:0] branchTarget;
        logic [31:0] aluResult;
        logic [31:0] writeData;
        logic        zero;
        logic [4:0]  writeReg;
        logic        ovf;
    } bundle_t;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN;
    logic [1:0]  ALUOpIN;
    logic [31:0] nextPcIN, readData1IN, readData2IN, signExtIN;
    logic [4:0]  ins20_16IN, ins15_11IN;
    logic        stall;
    logic        BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT;
    logic [31:0] branchTargetOUT, aluResultOUT, writeDataOUT;
    logic        zeroOUT;
    logic [4:0]  writeRegOUT;
    logic        ovfOUT;

    bundle_t obs;
    bundle_t exp;
    bundle_t masked;
    bundle_t sb[$];
    int      total = 0;
    int      bad   = 0;

    ex_mem_stage #(.WIDTH(32), .MUL_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .RegDstIN(RegDstIN), .BranchIN(BranchIN), .MemReadIN(MemReadIN), .MemtoRegIN(MemtoRegIN),
        .MemWriteIN(MemWriteIN), .ALUSrcIN(ALUSrcIN), .RegWriteIN(RegWriteIN), .ALUOpIN(ALUOpIN),
        .nextPcIN(nextPcIN), .readData1IN(readData1IN), .readData2IN(readData2IN), .signExtIN(signExtIN),
        .ins20_16IN(ins20_16IN), .ins15_11IN(ins15_11IN), .stall(stall),
        .BranchOUT(BranchOUT), .MemReadOUT(MemReadOUT), .MemtoRegOUT(MemtoRegOUT), .MemWriteOUT(MemWriteOUT),
        .RegWriteOUT(RegWriteOUT), .branchTargetOUT(branchTargetOUT), .aluResultOUT(aluResultOUT),
        .writeDataOUT(writeDataOUT), .zeroOUT(zeroOUT), .writeRegOUT(writeRegOUT), .ovfOUT(ovfOUT)
    );

    assign obs = {BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT,
                  branchTargetOUT, aluResultOUT, writeDataOUT, zeroOUT, writeRegOUT, ovfOUT};

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        flush = 1'b0;
        {RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN} = '0;
        ALUOpIN = 2'b00;
        nextPcIN = '0; readData1IN = '0; readData2IN = '0; signExtIN = '0;
        ins20_16IN = '0; ins15_11IN = '0;
    endtask

    task automatic setR(input logic [5:0] funct, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        clearInputs();
        ALUOpIN = 2'b10; RegDstIN = 1'b1; RegWriteIN = 1'b1;
        signExtIN = {26'd0, funct};
        readData1IN = a; readData2IN = b;
        ins15_11IN = rd; ins20_16IN = 5'd7;
    endtask

    // Reference for single-cycle instructions; overflow via 33-bit sign-extended arithmetic.
    function automatic bundle_t model();
        bundle_t m;
        logic [31:0] a, b, r;
        logic [32:0] wide;
        logic [5:0] f;
        logic trap;
        a = readData1IN;
        b = ALUSrcIN ? signExtIN : readData2IN;
        f = signExtIN[5:0];
        trap = 1'b0;
        wide = '0;
        if (ALUOpIN == 2'b01) r = a - b;
        else if (ALUOpIN == 2'b10) begin
            case (f)
                6'b100010: r = a - b;
                6'b100100: r = a & b;
                6'b100101: r = a | b;
                6'b101010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                default:   r = a + b;
            endcase
`ifdef EX_OVERFLOW_TRAP_EN
            if (f == 6'b100000) wide = {a[31], a} + {b[31], b};
            if (f == 6'b100010) wide = {a[31], a} - {b[31], b};
            if (f == 6'b100000 || f == 6'b100010) trap = (wide[32] != wide[31]);
`endif
        end else r = a + b;
        m.branch = BranchIN; m.memRead = MemReadIN; m.memtoReg = MemtoRegIN; m.memWrite = MemWriteIN;
        m.regWrite = RegWriteIN && !trap;
        m.branchTarget = nextPcIN + signExtIN * 32'd4;
        m.aluResult = r;
        m.writeData = readData2IN;
        m.zero = (r == 32'd0);
        m.writeReg = RegDstIN ? ins15_11IN : ins20_16IN;
        m.ovf = trap;
        return m;
    endfunction

    task automatic test_reset();
        {RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN} = 7'($urandom);
        nextPcIN = $urandom; readData1IN = $urandom; readData2IN = $urandom;
        signExtIN = {$urandom_range(0, 65535), 10'd0, 6'b011001};
        ALUOpIN = 2'b10; ins20_16IN = 5'($urandom); ins15_11IN = 5'($urandom);
        flush = 1'b0; rst = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall: got %b want 0", stall); end
        step();
        total++;
        if (obs !== '0) begin bad++; $display("[TB] FAIL reset_bundle: got %h want 0", obs); end
        rst = 1'b0;
        clearInputs();
    endtask

    task automatic test_add();
        setR(6'b100000, 32'd5, 32'd7, 5'd9);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'd12, 32'd7, 1'b0, 5'd9, 1'b0});
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL add_stall: got %b want 0", stall); end
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL add: got %h want %h", obs, exp); end
    endtask

    task automatic test_branch();
        clearInputs();
        ALUOpIN = 2'b01; BranchIN = 1'b1;
        readData1IN = 32'h10; readData2IN = 32'h10;
        nextPcIN = 32'h100; signExtIN = 32'd3; ins20_16IN = 5'd5; ins15_11IN = 5'd20;
        sb.push_back('{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10C, 32'd0, 32'h10, 1'b1, 5'd5, 1'b0});
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL beq: got %h want %h", obs, exp); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] functs [6];
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        for (int i = 0; i < 16; i++) begin
            {RegDstIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, ALUSrcIN, RegWriteIN} = 7'($urandom);
            ALUOpIN = 2'($urandom_range(0, 3));
            nextPcIN = $urandom; readData1IN = $urandom; readData2IN = $urandom;
            signExtIN = {$urandom_range(0, 67108863), functs[$urandom_range(0, 5)]};
            ins20_16IN = 5'($urandom); ins15_11IN = 5'($urandom);
            if (i % 4 == 0) begin readData2IN = readData1IN; ALUSrcIN = 1'b0; ALUOpIN = 2'b01; end
            sb.push_back(model());
            #1;
            total++;
            if (stall !== 1'b0) begin bad++; $display("[TB] FAIL b2b_stall[%0d]: got %b want 0", i, stall); end
            step();
            exp = sb.pop_front();
            total++;
            if (obs !== exp) begin bad++; $display("[TB] FAIL b2b[%0d]: got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic startMultu();
        setR(6'b011001, 32'h0001_0003, 32'h0000_0005, 5'd4);
        BranchIN = 1'b1; MemWriteIN = 1'b1;
    endtask

    task automatic test_multu();
        int n;
        startMultu();
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'h0005_000F, 32'd0, 1'b0, 5'd4, 1'b0});
        #1;
        n = 0;
        while (stall === 1'b1 && n < 100) begin
            if (n == 5) begin
                readData1IN = 32'hFFFF_FFFF; readData2IN = 32'h1234_5678; ins15_11IN = 5'd30;
            end
            step();
            n++;
            total++;
            if (obs !== '0) begin bad++; $display("[TB] FAIL mul_bubble[%0d]: got %h want 0", n, obs); end
        end
        total++;
        if (n !== 33) begin bad++; $display("[TB] FAIL mul_stall_cycles: got %0d want 33", n); end
        step();
        exp = sb.pop_front();
        masked = obs;
        masked.branchTarget = '0;
        masked.writeData = '0;
        total++;
        if (masked !== exp) begin bad++; $display("[TB] FAIL multu: got %h want %h", masked, exp); end
        setR(6'b100000, 32'd2, 32'd3, 5'd6);
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL post_mul_stall: got %b want 0", stall); end
        step();
        total++;
        if (aluResultOUT !== 32'd5) begin bad++; $display("[TB] FAIL post_mul_add: got %h want 5", aluResultOUT); end
    endtask

    task automatic test_flush();
        setR(6'b100000, 32'd9, 32'd9, 5'd8);
        flush = 1'b1;
        step();
        total++;
        if (obs !== '0) begin bad++; $display("[TB] FAIL flush_add: got %h want 0", obs); end
        startMultu();
        for (int i = 0; i < 11; i++) step();
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall: got %b want 0", stall); end
        step();
        total++;
        if (obs !== '0) begin bad++; $display("[TB] FAIL flush_bubble: got %h want 0", obs); end
        setR(6'b100000, 32'd1, 32'd1, 5'd2);
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'd2, 32'd1, 1'b0, 5'd2, 1'b0});
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL flush_next_stall: got %b want 0", stall); end
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL flush_next_add: got %h want %h", obs, exp); end
    endtask

    task automatic test_rst_mid_mul();
        startMultu();
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_stall: got %b want 0", stall); end
        step();
        rst = 1'b0;
        clearInputs();
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b1, 5'd0, 1'b0});
        for (int i = 0; i < 3; i++) begin
            step();
            exp = (i == 0) ? sb.pop_front() : exp;
            total++;
            if (obs !== exp) begin bad++; $display("[TB] FAIL rst_mid_nowb[%0d]: got %h want %h", i, obs, exp); end
        end
    endtask

    task automatic test_overflow();
        bundle_t e;
        setR(6'b100000, 32'h7FFF_FFFF, 32'd1, 5'd3);
`ifdef EX_OVERFLOW_TRAP_EN
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h80, 32'h8000_0000, 32'd1, 1'b0, 5'd3, 1'b1};
`else
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h8000_0000, 32'd1, 1'b0, 5'd3, 1'b0};
`endif
        sb.push_back(e);
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL ovf_funct_add: got %h want %h", obs, exp); end
        ALUOpIN = 2'b00;
        sb.push_back('{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 32'h8000_0000, 32'd1, 1'b0, 5'd3, 1'b0});
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL ovf_aluop00: got %h want %h", obs, exp); end
        setR(6'b100010, 32'h8000_0000, 32'd1, 5'd11);
        sb.push_back(model());
        step();
        exp = sb.pop_front();
        total++;
        if (obs !== exp) begin bad++; $display("[TB] FAIL ovf_funct_sub: got %h want %h", obs, exp); end
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        step();
        test_reset();
        test_add();
        test_branch();
        test_back_to_back();
        test_multu();
        test_flush();
        test_multu();
        test_rst_mid_mul();
        test_multu();
        test_overflow();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
